// File: rtl/val2_shift_pipe_pkg.sv
// rtl/val2_shift_pipe_pkg.sv - shift-type and Val2 mode encodings shared by the shifter pipeline
package val2_shift_pipe_pkg;

  // Instruction bits [11:0] that form the shifter operand field
  localparam int LEN_SHIFT_OPERAND = 12;

  // Shift-type encodings of instruction bits [6:5]
  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  // Operand mode decoded in stage 1 and consumed by the barrel shifter
  typedef enum logic [2:0] {
    VAL2_MODE_IMM_SHIFT = 3'd0,
    VAL2_MODE_REG_SHIFT = 3'd1,
    VAL2_MODE_IMM       = 3'd2,
    VAL2_MODE_MEM       = 3'd3,
    VAL2_MODE_ILLEGAL   = 3'd4
  } val2_mode_e;

endpackage

// File: rtl/val2_barrel_shifter.sv
// rtl/val2_barrel_shifter.sv - combinational Val2 shifter with ARM carry-out rules
module val2_barrel_shifter
  import val2_shift_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_op,
  input  logic [7:0]       i_amount,
  input  logic [1:0]       i_type,
  input  logic             i_cin,
  input  val2_mode_e       i_mode,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  localparam int         AW = $clog2(WIDTH);
  localparam logic [7:0] W8 = 8'(WIDTH);

  logic [AW-1:0]      w_sh;
  logic               w_msb;
  logic [WIDTH:0]     w_lsl;
  logic [WIDTH:0]     w_lsr;
  logic [WIDTH:0]     w_asr;
  logic [2*WIDTH-1:0] w_ror2;
  logic [WIDTH-1:0]   w_ror;
  logic               w_unused_ror;

  // The extra bit on each shift catches the last bit shifted out (the carry);
  // w_sh is only meaningful when the full 8-bit amount is below WIDTH, except
  // for rotates where the low bits are exactly amount mod WIDTH.
  assign w_sh         = i_amount[AW-1:0];
  assign w_msb        = i_op[WIDTH-1];
  assign w_lsl        = {1'b0, i_op} << w_sh;
  assign w_lsr        = {i_op, 1'b0} >> w_sh;
  assign w_asr        = $signed({i_op, 1'b0}) >>> w_sh;
  assign w_ror2       = {i_op, i_op} >> w_sh;
  assign w_ror        = w_ror2[WIDTH-1:0];
  assign w_unused_ror = ^w_ror2[2*WIDTH-1:WIDTH];

  // Select result and carry by mode, then by shift type and range of the amount
  always_comb begin
    o_result = '0;
    o_carry  = i_cin;
    case (i_mode)
      VAL2_MODE_MEM: begin
        o_result = i_op;
        o_carry  = i_cin;
      end
      VAL2_MODE_IMM: begin
        o_result = w_ror;
        o_carry  = (i_amount == 8'd0) ? i_cin : w_ror[WIDTH-1];
      end
      VAL2_MODE_IMM_SHIFT, VAL2_MODE_REG_SHIFT: begin
        if (i_amount == 8'd0) begin
          o_result = i_op;
          o_carry  = i_cin;
          // A zero immediate amount re-encodes LSR/ASR #32 and RRX
          if (i_mode == VAL2_MODE_IMM_SHIFT) begin
            case (i_type)
              SHIFT_LSR: begin
                o_result = '0;
                o_carry  = w_msb;
              end
              SHIFT_ASR: begin
                o_result = {WIDTH{w_msb}};
                o_carry  = w_msb;
              end
              SHIFT_ROR: begin
                o_result = {i_cin, i_op[WIDTH-1:1]};
                o_carry  = i_op[0];
              end
              default: begin
                o_result = i_op;
                o_carry  = i_cin;
              end
            endcase
          end
        end else begin
          case (i_type)
            SHIFT_LSL: begin
              if (i_amount < W8) begin
                o_result = w_lsl[WIDTH-1:0];
                o_carry  = w_lsl[WIDTH];
              end else begin
                o_result = '0;
                o_carry  = (i_amount == W8) ? i_op[0] : 1'b0;
              end
            end
            SHIFT_LSR: begin
              if (i_amount < W8) begin
                o_result = w_lsr[WIDTH:1];
                o_carry  = w_lsr[0];
              end else begin
                o_result = '0;
                o_carry  = (i_amount == W8) ? w_msb : 1'b0;
              end
            end
            SHIFT_ASR: begin
              if (i_amount < W8) begin
                o_result = w_asr[WIDTH:1];
                o_carry  = w_asr[0];
              end else begin
                o_result = {WIDTH{w_msb}};
                o_carry  = w_msb;
              end
            end
            default: begin
              if (w_sh == '0) begin
                o_result = i_op;
                o_carry  = w_msb;
              end else begin
                o_result = w_ror;
                o_carry  = w_ror[WIDTH-1];
              end
            end
          endcase
        end
      end
      default: begin
        o_result = '0;
        o_carry  = i_cin;
      end
    endcase
  end

endmodule

// File: rtl/val2_shift_pipe.sv
// rtl/val2_shift_pipe.sv - two-stage Val2 shifter-operand pipeline with valid/ready flow control
module val2_shift_pipe
  import val2_shift_pipe_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TAG_W          = 4,
  parameter bit MEM_OFF_SIGNED = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_op,
  input  logic [WIDTH-1:0]             in_rs,
  input  logic                         in_is_imm,
  input  logic                         in_is_mem,
  input  logic [LEN_SHIFT_OPERAND-1:0] in_shift_operand,
  input  logic                         in_carry,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_result,
  output logic                         out_carry,
  output logic                         out_illegal,
  output logic [TAG_W-1:0]             out_tag
);

  logic                         w_s1_adv;
  logic                         w_s2_adv;
  logic [LEN_SHIFT_OPERAND-1:0] w_so;
  logic [WIDTH-1:0]             w_mem_off;
  val2_mode_e                   w_mode;
  logic [7:0]                   w_amount;
  logic [1:0]                   w_type;
  logic [WIDTH-1:0]             w_operand;
  logic [WIDTH-1:0]             w_shift_result;
  logic                         w_shift_carry;
  logic                         w_unused_rs;

  val2_mode_e                   r_s1_mode;
  logic                         r_s1_valid;
  logic [7:0]                   r_s1_amount;
  logic [1:0]                   r_s1_type;
  logic [WIDTH-1:0]             r_s1_operand;
  logic                         r_s1_cin;
  logic [TAG_W-1:0]             r_s1_tag;
  logic                         r_s2_valid;
  logic [WIDTH-1:0]             r_s2_result;
  logic                         r_s2_carry;
  logic                         r_s2_illegal;
  logic [TAG_W-1:0]             r_s2_tag;

  // Only the low byte of Rs is a shift amount
  assign w_unused_rs = ^in_rs[WIDTH-1:8];
  assign w_so        = in_shift_operand;
  assign w_mem_off   = MEM_OFF_SIGNED
                       ? {{(WIDTH-LEN_SHIFT_OPERAND){w_so[LEN_SHIFT_OPERAND-1]}}, w_so}
                       : {{(WIDTH-LEN_SHIFT_OPERAND){1'b0}}, w_so};

  // A stage may load when it is empty or the stage after it is moving
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Decode the operand mode with priority mem > imm > reg-shift > imm-shift
  always_comb begin
    w_mode    = VAL2_MODE_IMM_SHIFT;
    w_amount  = {3'b000, w_so[11:7]};
    w_type    = w_so[6:5];
    w_operand = in_op;
    if (in_is_mem) begin
      w_mode    = VAL2_MODE_MEM;
      w_amount  = 8'd0;
      w_operand = w_mem_off;
    end else if (in_is_imm) begin
      w_mode    = VAL2_MODE_IMM;
      w_amount  = {3'b000, w_so[11:8], 1'b0};
      w_type    = SHIFT_ROR;
      w_operand = {{(WIDTH-8){1'b0}}, w_so[7:0]};
    end else if (w_so[4]) begin
      if (w_so[7]) begin
        w_mode   = VAL2_MODE_ILLEGAL;
        w_amount = 8'd0;
      end else begin
        w_mode   = VAL2_MODE_REG_SHIFT;
        w_amount = in_rs[7:0];
      end
    end
  end

  // Stage 1: capture the decoded operation on an accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_mode    <= VAL2_MODE_IMM_SHIFT;
      r_s1_amount  <= '0;
      r_s1_type    <= '0;
      r_s1_operand <= '0;
      r_s1_cin     <= 1'b0;
      r_s1_tag     <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode    <= w_mode;
        r_s1_amount  <= w_amount;
        r_s1_type    <= w_type;
        r_s1_operand <= w_operand;
        r_s1_cin     <= in_carry;
        r_s1_tag     <= in_tag;
      end
    end
  end

  val2_barrel_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_op     (r_s1_operand),
    .i_amount (r_s1_amount),
    .i_type   (r_s1_type),
    .i_cin    (r_s1_cin),
    .i_mode   (r_s1_mode),
    .o_result (w_shift_result),
    .o_carry  (w_shift_carry)
  );

  // Stage 2: register the shifter result; holds bit-stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_result  <= '0;
      r_s2_carry   <= 1'b0;
      r_s2_illegal <= 1'b0;
      r_s2_tag     <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result  <= w_shift_result;
        r_s2_carry   <= w_shift_carry;
        r_s2_illegal <= (r_s1_mode == VAL2_MODE_ILLEGAL);
        r_s2_tag     <= r_s1_tag;
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_carry   = r_s2_carry;
  assign out_illegal = r_s2_illegal;
  assign out_tag     = r_s2_tag;

endmodule

// File: tb/tb_val2_shift_pipe.sv
// tb/tb_val2_shift_pipe.sv - self-checking bench for val2_shift_pipe
module tb_val2_shift_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op;
  logic [31:0] in_rs;
  logic        in_is_imm;
  logic        in_is_mem;
  logic [11:0] in_shift_operand;
  logic        in_carry;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic        out_illegal;
  logic [3:0]  out_tag;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] op;
    logic [31:0] rs;
    logic        is_imm;
    logic        is_mem;
    logic [11:0] so;
    logic        cin;
    logic [31:0] exp_result;
    logic        exp_carry;
    logic        exp_ill;
  } vec_t;

  vec_t vq[$];

  val2_shift_pipe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_op            (in_op),
    .in_rs            (in_rs),
    .in_is_imm        (in_is_imm),
    .in_is_mem        (in_is_mem),
    .in_shift_operand (in_shift_operand),
    .in_carry         (in_carry),
    .in_tag           (in_tag),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_carry        (out_carry),
    .out_illegal      (out_illegal),
    .out_tag          (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_imm(input logic [7:0] imm8, input logic [3:0] tag);
    in_op            = 32'h0;
    in_rs            = 32'h0;
    in_is_imm        = 1'b1;
    in_is_mem        = 1'b0;
    in_shift_operand = {4'h0, imm8};
    in_carry         = 1'b0;
    in_tag           = tag;
  endtask

  initial begin
    int          sent;
    int          rcvd;
    int          cyc;
    int          lat;
    bit          got;
    bit          prev_stall;
    bit          seen;
    logic [36:0] prev_out;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive_imm(8'h00, 4'h0);

    // op, rs, imm, mem, shift_operand, cin, result, carry, illegal
    vq.push_back('{32'h0, 32'h0, 1'b1, 1'b0, 12'h4FF, 1'b0, 32'hFF000000, 1'b1, 1'b0});
    vq.push_back('{32'h0, 32'h0, 1'b1, 1'b0, 12'h0FF, 1'b1, 32'h000000FF, 1'b1, 1'b0});
    vq.push_back('{32'h80000001, 32'h0, 1'b0, 1'b0, 12'h020, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vq.push_back('{32'h80000001, 32'h0, 1'b0, 1'b0, 12'h040, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
    vq.push_back('{32'h80000001, 32'h0, 1'b0, 1'b0, 12'h060, 1'b1, 32'hC0000000, 1'b1, 1'b0});
    vq.push_back('{32'h80000001, 32'd32, 1'b0, 1'b0, 12'h010, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vq.push_back('{32'h80000001, 32'd33, 1'b0, 1'b0, 12'h030, 1'b1, 32'h00000000, 1'b0, 1'b0});
    vq.push_back('{32'h80000001, 32'd36, 1'b0, 1'b0, 12'h070, 1'b1, 32'h18000000, 1'b0, 1'b0});
    vq.push_back('{32'h80000001, 32'h100, 1'b0, 1'b0, 12'h010, 1'b1, 32'h80000001, 1'b1, 1'b0});
    vq.push_back('{32'h80000001, 32'd5, 1'b0, 1'b0, 12'h090, 1'b1, 32'h00000000, 1'b1, 1'b1});
    vq.push_back('{32'h80000001, 32'd0, 1'b1, 1'b1, 12'hABC, 1'b0, 32'h00000ABC, 1'b0, 1'b0});
    vq.push_back('{32'h12345678, 32'd0, 1'b0, 1'b0, 12'h000, 1'b1, 32'h12345678, 1'b1, 1'b0});
    vq.push_back('{32'hF0000001, 32'd0, 1'b0, 1'b0, 12'h200, 1'b0, 32'h00000010, 1'b1, 1'b0});
    vq.push_back('{32'h0000001F, 32'd0, 1'b0, 1'b0, 12'h220, 1'b0, 32'h00000001, 1'b1, 1'b0});
    vq.push_back('{32'h80000080, 32'd0, 1'b0, 1'b0, 12'h440, 1'b0, 32'hFF800000, 1'b1, 1'b0});
    vq.push_back('{32'h7FFFFFFF, 32'd40, 1'b0, 1'b0, 12'h050, 1'b1, 32'h00000000, 1'b0, 1'b0});
    vq.push_back('{32'h80000001, 32'd1, 1'b0, 1'b0, 12'h010, 1'b0, 32'h00000002, 1'b1, 1'b0});
    vq.push_back('{32'h80000001, 32'd32, 1'b0, 1'b0, 12'h070, 1'b0, 32'h80000001, 1'b1, 1'b0});
    vq.push_back('{32'h80000001, 32'd32, 1'b0, 1'b0, 12'h030, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vq.push_back('{32'h0, 32'd0, 1'b0, 1'b1, 12'hFFF, 1'b1, 32'h00000FFF, 1'b1, 1'b0});
    vq.push_back('{32'h0, 32'd0, 1'b1, 1'b0, 12'h09F, 1'b0, 32'h0000009F, 1'b0, 1'b0});
    vq.push_back('{32'h000000A5, 32'd0, 1'b0, 1'b0, 12'h460, 1'b0, 32'hA5000000, 1'b1, 1'b0});
    vq.push_back('{32'h00000003, 32'd31, 1'b0, 1'b0, 12'h010, 1'b0, 32'h80000000, 1'b1, 1'b0});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {27'h0, out_valid, out_result, out_carry, out_illegal, out_tag},
          64'h0);
    check("reset_in_ready", {63'h0, in_ready}, 64'h1);
    rst_n = 1'b1;

    // Table-driven single operations with out_ready held high
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      in_op            = vq[i].op;
      in_rs            = vq[i].rs;
      in_is_imm        = vq[i].is_imm;
      in_is_mem        = vq[i].is_mem;
      in_shift_operand = vq[i].so;
      in_carry         = vq[i].cin;
      in_tag           = 4'(i);
      in_valid         = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      got = 1'b0;
      lat = 0;
      for (int k = 1; k <= 4 && !got; k++) begin
        @(negedge clk);
        if (out_valid) begin
          got = 1'b1;
          lat = k;
        end
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_out", i), {26'h0, out_result, out_carry, out_illegal, out_tag},
            {26'h0, vq[i].exp_result, vq[i].exp_carry, vq[i].exp_ill, 4'(i)});
    end

    // Back-to-back ops with random backpressure: order, tags, no loss, stall stability
    sent       = 0;
    rcvd       = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    while (rcvd < 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prev_stall)
        check($sformatf("stall_hold%0d", rcvd), {27'h0, out_valid, out_result, out_tag},
              {27'h0, 1'b1, prev_out[35:0]});
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      drive_imm(8'(8'h10 + sent), 4'(sent));
      #1;
      if (out_valid && out_ready) begin
        check($sformatf("bp_out%0d", rcvd), {27'h0, out_result, out_carry, out_tag},
              {27'h0, 32'(32'h10 + rcvd), 1'b0, 4'(rcvd)});
        rcvd++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {1'b0, out_result, out_tag};
      @(posedge clk);
      if (in_valid && in_ready) sent++;
    end
    #1 in_valid = 1'b0;
    check("bp_received_all", 64'(rcvd), 64'd8);
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("bp_no_duplicate", {63'h0, seen}, 64'h0);

    // Reset while two ops are in flight and the output is stalled
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive_imm(8'h55, 4'h9);
    @(posedge clk);
    @(negedge clk);
    drive_imm(8'h66, 4'hA);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("inflight_valid", {63'h0, out_valid}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", {27'h0, out_valid, out_result, out_carry, out_illegal, out_tag},
          64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_emit_after_reset", {63'h0, seen}, 64'h0);
    in_valid = 1'b1;
    drive_imm(8'h77, 4'hB);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_s1_only", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    check("post_reset_out", {27'h0, out_valid, out_result, out_tag},
          {27'h0, 1'b1, 32'h00000077, 4'hB});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
